fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg: shared fetch-path defaults and the prefetch queue entry type.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 24;
  localparam int DEF_DEPTH  = 4;

  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo: synchronous power-of-two FIFO with flush and occupancy count.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEF_INST_W + DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is only ever read behind a non-zero count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit: sequential instruction prefetcher with redirect and queue.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_rd,
  input  logic [INST_W-1:0]        imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INST_W-1:0]        out_inst,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     occupancy;
  logic [EW-1:0]     fifo_head;
  logic              fifo_push;
  logic              fifo_pop;

  // Occupancy counts reads still in flight so a response always has a slot.
  always_comb begin
    occupancy  = fifo_count + CW'(inflight_q);
    imem_rd    = reset && !redirect_valid && (occupancy < CW'(DEPTH));
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = imem_rd;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_rd) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      tag_d      = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    fifo_push = inflight_q && !redirect_valid;
    out_valid = reset && !redirect_valid && (fifo_count != '0);
    fifo_pop  = out_valid && out_ready;
    out_inst  = out_valid ? fifo_head[EW-1:ADDR_W] : '0;
    out_pc    = out_valid ? fifo_head[ADDR_W-1:0]  : '0;
    imem_addr = reset ? fetch_pc_q : RESET_PC;
    count     = fifo_count;
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data ({imem_rdata, tag_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit: directed and randomized checks of fetch_unit against a model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;
  localparam logic [15:0] RPC_W = 16'hFFFE;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        out_ready = 1'b1;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [23:0] imem_rdata = 24'h0;
  logic        out_valid;
  logic [23:0] out_inst;
  logic [15:0] out_pc;
  logic [2:0]  count;

  logic [15:0] w_imem_addr;
  logic        w_imem_rd;
  logic [23:0] w_imem_rdata = 24'h0;
  logic        w_out_valid;
  logic [23:0] w_out_inst;
  logic [15:0] w_out_pc;
  logic [2:0]  w_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [23:0] mem_word(input logic [15:0] a);
    return 24'(a) + 24'h100000;
  endfunction

  // Memory answers one cycle after a read; junk otherwise to expose bad captures.
  always @(posedge clk) begin
    imem_rdata   <= imem_rd   ? mem_word(imem_addr)   : 24'($urandom);
    w_imem_rdata <= w_imem_rd ? mem_word(w_imem_addr) : 24'($urandom);
  end

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .count(count)
  );

  fetch_unit #(.RESET_PC(RPC_W)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_rd(w_imem_rd),
    .imem_rdata(w_imem_rdata), .redirect_valid(1'b0), .redirect_pc(16'h0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_inst(w_out_inst),
    .out_pc(w_out_pc), .count(w_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {inst,pc}, one outstanding read, a fetch pointer.
  fetch_entry_t mq[$];
  logic        m_inf = 1'b0;
  logic [15:0] m_inf_pc = 16'h0;
  logic [15:0] m_pc = RPC;
  logic [15:0] next_pc = RPC;
  logic        started = 1'b0;

  always @(posedge clk) started <= 1'b1;

  always @(negedge clk) begin
    logic        e_rd, e_valid;
    logic [15:0] e_addr, e_pc;
    logic [23:0] e_inst;
    e_rd    = reset && !redirect_valid && ((mq.size() + int'(m_inf)) < DEPTH);
    e_valid = reset && !redirect_valid && (mq.size() > 0);
    e_addr  = reset ? m_pc : RPC;
    e_pc    = e_valid ? mq[0].pc   : 16'h0;
    e_inst  = e_valid ? mq[0].inst : 24'h0;
    if (started) begin
      check("imem_rd",   32'(imem_rd),   32'(e_rd));
      check("imem_addr", 32'(imem_addr), 32'(e_addr));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("out_pc",    32'(out_pc),    32'(e_pc));
      check("out_inst",  32'(out_inst),  32'(e_inst));
      check("count",     32'(count),     32'(mq.size()));
      check("count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
      if (out_valid && out_ready) begin
        check("program_order", 32'(out_pc), 32'(next_pc));
        next_pc = out_pc + 16'd1;
      end
    end
    if (!reset) begin
      mq.delete();
      m_inf   = 1'b0;
      m_pc    = RPC;
      next_pc = RPC;
    end else begin
      if (e_valid && out_ready) void'(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        m_inf   = 1'b0;
        m_pc    = redirect_pc;
        next_pc = redirect_pc;
      end else begin
        if (m_inf) mq.push_back(fetch_entry_t'{inst: mem_word(m_inf_pc), pc: m_inf_pc});
        m_inf    = e_rd;
        m_inf_pc = m_pc;
        if (e_rd) m_pc = m_pc + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] wexp [4];
    int gap;
    wexp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    // Held in reset.
    repeat (3) tick();
    #2;
    check("rst_imem_rd",   32'(imem_rd),     32'd0);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_out_pc",    32'(out_pc),      32'd0);
    check("rst_out_inst",  32'(out_inst),    32'd0);
    check("rst_count",     32'(count),       32'd0);
    check("rst_addr",      32'(imem_addr),   32'h0);
    check("rst_addr_w",    32'(w_imem_addr), 32'hFFFE);

    // Release: streaming fill, one instruction per cycle from the second cycle.
    tick(); reset = 1'b1; #2;
    check("rel_rd",   32'(imem_rd),   32'd1);
    check("rel_addr", 32'(imem_addr), 32'h0);
    tick(); #2;
    check("rel1_valid", 32'(out_valid), 32'd0);
    check("rel1_addr",  32'(imem_addr), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick(); #2;
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc",    32'(out_pc),    32'(k));
      check("stream_inst",  32'(out_inst),  32'h100000 + 32'(k));
      if (k < 4) begin
        check("wrap_pc",   32'(w_out_pc),   32'(wexp[k]));
        check("wrap_inst", 32'(w_out_inst), 32'h100000 + 32'(wexp[k]));
      end
    end

    // Consumer stall: queue saturates, no overwrite, order kept on release.
    tick(); out_ready = 1'b0; #2;
    check("stall_head", 32'(out_pc), 32'd6);
    repeat (9) tick();
    #2;
    check("stall_count", 32'(count),   32'd4);
    check("stall_rd",    32'(imem_rd), 32'd0);
    check("stall_pc",    32'(out_pc),  32'd6);
    for (int k = 0; k < 5; k++) begin
      tick(); if (k == 0) out_ready = 1'b1; #2;
      check("drain_pc", 32'(out_pc), 32'd6 + 32'(k));
    end

    // Reset pulse with two queued entries and a read outstanding.
    tick(); reset = 1'b0; #2;
    check("midrst_count_before", 32'(count),     32'd2);
    check("midrst_valid",        32'(out_valid), 32'd0);
    check("midrst_rd",           32'(imem_rd),   32'd0);
    tick(); #2;
    check("midrst_count", 32'(count),     32'd0);
    check("midrst_addr",  32'(imem_addr), 32'h0);
    check("midrst_pc",    32'(out_pc),    32'd0);
    tick(); reset = 1'b1; #2;
    check("restart_rd",   32'(imem_rd),   32'd1);
    check("restart_addr", 32'(imem_addr), 32'h0);
    tick(); tick(); #2;
    check("restart_pc", 32'(out_pc), 32'd0);

    // Redirect with three queued entries.
    tick(); out_ready = 1'b0;
    tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0040; #2;
    check("redir_count", 32'(count),     32'd3);
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_rd",    32'(imem_rd),   32'd0);
    tick(); redirect_valid = 1'b0; out_ready = 1'b1; #2;
    check("redir1_count", 32'(count),     32'd0);
    check("redir1_addr",  32'(imem_addr), 32'h40);
    check("redir1_rd",    32'(imem_rd),   32'd1);
    tick(); #2;
    check("redir2_valid", 32'(out_valid), 32'd0);
    tick(); #2;
    check("redir3_pc",   32'(out_pc),   32'h40);
    check("redir3_inst", 32'(out_inst), 32'h100040);

    // Back-to-back redirects: the later target wins.
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick(); redirect_pc = 16'h0300;
    tick(); redirect_valid = 1'b0; #2;
    check("b2b_addr", 32'(imem_addr), 32'h300);
    tick(); tick(); #2;
    check("b2b_pc", 32'(out_pc), 32'h300);

    // Randomized consumer and periodic redirects, checked by the model.
    gap = int'($urandom_range(13, 7));
    for (int c = 0; c < 10000; c++) begin
      tick();
      out_ready = 1'($urandom_range(1, 0));
      if (gap == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(3, 0) == 0) ? 16'hFFFD : 16'($urandom);
        gap            = int'($urandom_range(13, 7));
      end else begin
        redirect_valid = 1'b0;
        gap--;
      end
    end
    tick(); redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
